// File: rtl/serial_pkg.sv
// ============================================================================
//  Module      : serial_pkg
//  Description : Definitions shared by the serial receiver and the future
//                transmitter: the receiver state encoding and the
//                parity-mode codes carried on parity_mode_i.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Parity modes. Code 3 is decoded as "no parity".
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_rx_sampler.sv
// ============================================================================
//  Module      : serial_rx_sampler
//  Description : Input conditioning for the serial receiver. A two-flop
//                synchroniser brings rx into the clock domain, and a
//                three-sample majority vote over the synchronised history
//                rejects single-clock noise.
//  Ports       : clk_i   system clock
//                rst_ni  asynchronous active-low reset
//                rx_i    raw serial line (idle high)
//                rx_s_o  synchronised line
//                rx_m_o  majority-voted line
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_rx_sampler (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_m_o
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    // Both stages reset to the idle level so no false start appears
    // on reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    assign rx_s_o = sync_q[1];
    assign rx_m_o = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);

endmodule

`default_nettype wire

// File: rtl/serial_rx_frame.sv
// ============================================================================
//  Module      : serial_rx_frame
//  Description : Parametrised UART receiver. Configurable data width and
//                stop-bit count. Start-bit glitch rejection and per-frame
//                frame, parity and break flags. Output is a valid/ready
//                holding register with overrun reporting.
//                Build option: define SERIAL_RX_PARITY_EN to include the
//                parity stage (parity_mode_i decode, parity_err_o).
//                Without it, frames are data plus stop bits only and
//                parity_err_o is tied low.
//  Ports       : clk_i, rst_ni       clock, asynchronous active-low reset
//                rx_i                serial line, idle high
//                parity_mode_i       0 none, 1 even, 2 odd, 3 none
//                data_o, out_valid_o received word / holding register full
//                out_ready_i         consumer accept
//                frame_err_o         stop bit sampled low
//                parity_err_o        parity mismatch
//                brk_o               break (data and first stop bit low)
//                overrun_o           one-cycle pulse: completed frame dropped
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_rx_frame
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 27,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [1:0]           parity_mode_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 brk_o,
    output logic                 overrun_o
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_CTR_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] C_CTR_HALF  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);

    logic w_rx_s;
    logic w_rx_m;

    serial_rx_sampler u_sampler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rx_i   (rx_i),
        .rx_s_o (w_rx_s),
        .rx_m_o (w_rx_m)
    );

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          ctr_q, ctr_d;
    logic [BW-1:0]          bit_ctr_q, bit_ctr_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   stop0_low_q, stop0_low_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   fe_q, fe_d;
    logic                   brk_q, brk_d;
    logic                   overrun_q, overrun_d;
    logic                   w_commit;
    logic                   w_brk;
    logic                   w_par_on;

`ifdef SERIAL_RX_PARITY_EN
    logic [1:0]             mode_q, mode_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   pe_q, pe_d;

    assign w_par_on = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
`else
    logic                   w_unused_mode;

    assign w_unused_mode = ^parity_mode_i;
    assign w_par_on      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            bit_ctr_q   <= '0;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            stop0_low_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            fe_q        <= 1'b0;
            brk_q       <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            mode_q      <= PAR_NONE;
            perr_acc_q  <= 1'b0;
            pe_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            bit_ctr_q   <= bit_ctr_d;
            shift_q     <= shift_d;
            ferr_acc_q  <= ferr_acc_d;
            stop0_low_q <= stop0_low_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            fe_q        <= fe_d;
            brk_q       <= brk_d;
            overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
            mode_q      <= mode_d;
            perr_acc_q  <= perr_acc_d;
            pe_q        <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        bit_ctr_d   = bit_ctr_q;
        shift_d     = shift_q;
        ferr_acc_d  = ferr_acc_q;
        stop0_low_d = stop0_low_q;
        data_d      = data_q;
        valid_d     = valid_q;
        fe_d        = fe_q;
        brk_d       = brk_q;
        overrun_d   = 1'b0;
        w_commit    = 1'b0;
        w_brk       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        mode_d      = mode_q;
        perr_acc_d  = perr_acc_q;
        pe_d        = pe_q;
`endif

        // Handshake empties the holding register; a commit below may refill it.
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                ctr_d       = '0;
                bit_ctr_d   = '0;
                ferr_acc_d  = 1'b0;
                stop0_low_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                mode_d      = parity_mode_i;
                perr_acc_d  = 1'b0;
`endif
                if (!w_rx_s) begin
                    state_d = ST_START;
                end
            end

            // Re-check the line at mid start bit; if it is high again, the
            // falling edge was a glitch.
            ST_START: begin
                if (ctr_q == C_CTR_HALF) begin
                    ctr_d   = '0;
                    state_d = w_rx_m ? ST_IDLE : ST_DATA;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end

            // Bits arrive LSB first, so shifting in at the MSB leaves the
            // word aligned once the last bit is captured.
            ST_DATA: begin
                if (ctr_q == C_CTR_LAST) begin
                    ctr_d   = '0;
                    shift_d = {w_rx_m, shift_q[DATA_BITS-1:1]};
                    if (bit_ctr_q == C_DATA_LAST) begin
                        bit_ctr_d = '0;
                        state_d   = w_par_on ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_ctr_d = bit_ctr_q + BW'(1);
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (ctr_q == C_CTR_LAST) begin
                    ctr_d      = '0;
                    perr_acc_d = ((^shift_q) ^ w_rx_m) != (mode_q == PAR_ODD);
                    state_d    = ST_STOP;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
`endif

            // bit_ctr is reused here to count stop bits.
            ST_STOP: begin
                if (ctr_q == C_CTR_LAST) begin
                    ctr_d = '0;
                    if (bit_ctr_q == '0) begin
                        stop0_low_d = ~w_rx_m;
                    end
                    if (bit_ctr_q == C_STOP_LAST) begin
                        w_commit = 1'b1;
                        w_brk    = (shift_q == '0) &&
                                   ((bit_ctr_q == '0) ? ~w_rx_m : stop0_low_q);
                        state_d  = w_brk ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        bit_ctr_d  = bit_ctr_q + BW'(1);
                        ferr_acc_d = ferr_acc_q | ~w_rx_m;
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end

            // After a break, wait for the line to return high before hunting
            // for the next start bit.
            ST_WAIT_HIGH: begin
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_commit) begin
            if (!valid_q || out_ready_i) begin
                data_d  = shift_q;
                fe_d    = ferr_acc_q | ~w_rx_m;
                brk_d   = w_brk;
                valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                pe_d    = perr_acc_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign out_valid_o = valid_q;
    assign frame_err_o = fe_q;
    assign brk_o       = brk_q;
    assign overrun_o   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err_o = pe_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_rx_frame.sv
// ============================================================================
//  Module      : tb_serial_rx_frame
//  Description : Self-checking bench for serial_rx_frame. Frames are built
//                bit by bit on rx_i, the expected word and flags are
//                computed from the frame contents and queued, and a monitor
//                compares them at every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_rx_frame;

    localparam int CPB = 27;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_i = 1'b1;
    logic          out_ready_i = 1'b1;
    logic [1:0]    parity_mode_i = 2'd0;
    logic [DB-1:0] data_o;
    logic          out_valid_o;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          brk_o;
    logic          overrun_o;

    typedef struct packed {
        logic [DB-1:0] d;
        logic          fe;
        logic          pe;
        logic          bk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_ovr    = 0;

    always #5 clk_i = ~clk_i;

    serial_rx_frame #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rx_i          (rx_i),
        .parity_mode_i (parity_mode_i),
        .data_o        (data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .frame_err_o   (frame_err_o),
        .parity_err_o  (parity_err_o),
        .brk_o         (brk_o),
        .overrun_o     (overrun_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: inputs change on the falling edge, outputs on the rising
    // edge, so 1 time unit after the falling edge both are stable.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && overrun_o) n_ovr++;
            if (rst_ni && out_valid_o && out_ready_i) begin
                n_acc++;
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data",    32'(data_o),       32'(e.d));
                    check("frame_err",  32'(frame_err_o),  32'(e.fe));
                    check("parity_err", 32'(parity_err_o), 32'(e.pe));
                    check("break",      32'(brk_o),        32'(e.bk));
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},      32'(data_o),       32'd0);
        check({tag, "_valid"},     32'(out_valid_o),  32'd0);
        check({tag, "_frame_err"}, 32'(frame_err_o),  32'd0);
        check({tag, "_par_err"},   32'(parity_err_o), 32'd0);
        check({tag, "_brk"},       32'(brk_o),        32'd0);
        check({tag, "_overrun"},   32'(overrun_o),    32'd0);
    endtask

    // Reference: the expected result follows from the frame contents alone.
    // A low stop bit is held low for two thirds of the bit, which covers the
    // receiver's sample point, then returns high.
    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] mode,
                              input bit flip_par, input bit stop_low,
                              input bit expect_out, input bit ready_at_stop,
                              input int gap);
        exp_t e;
        bit   par_on;
        logic pbit;
        int   ones;
        par_on = PAR_BUILD && (mode == 2'd1 || mode == 2'd2);
        pbit   = ((^d) ^ (mode == 2'd2)) ^ flip_par;
        ones   = $countones(d) + int'(pbit);
        e.d    = d;
        e.fe   = stop_low;
        e.pe   = par_on && (((ones % 2) == 1) != (mode == 2'd2));
        e.bk   = (d == '0) && stop_low;
        if (expect_out) exp_q.push_back(e);
        parity_mode_i = mode;
        drive(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive(d[i], CPB);
        if (par_on) drive(pbit, CPB);
        if (ready_at_stop) out_ready_i = 1'b1;
        for (int s = 0; s < SB; s++) begin
            if (stop_low && s == 0) begin
                drive(1'b0, CPB * 2 / 3);
                drive(1'b1, CPB - CPB * 2 / 3);
            end else begin
                drive(1'b1, CPB);
            end
        end
        drive(1'b1, gap * CPB);
    endtask

    initial begin : stim
        int   acc0;
        int   ovr0;
        logic [DB-1:0] d;

        repeat (3) @(negedge clk_i);
        #1;
        check_reset_values("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b1, 2 * CPB);

        // Plain 8N1 frame
        send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
`ifdef SERIAL_RX_PARITY_EN
        // Even parity, wrong parity bit
        send_frame(8'h07, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2);
`endif
        // Stop bit low
        send_frame(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2);

        // Break: line low for 20 bit times gives exactly one frame
        parity_mode_i = 2'd0;
        exp_q.push_back('{d: '0, fe: 1'b1, pe: 1'b0, bk: 1'b1});
        acc0 = n_acc;
        drive(1'b0, 20 * CPB);
        check("brk_frame_count", 32'(n_acc - acc0), 32'd1);
        drive(1'b1, 2 * CPB);

        // Short glitch on an idle line
        acc0 = n_acc;
        drive(1'b0, 10);
        drive(1'b1, 3 * CPB);
        #1;
        check("glitch_valid", 32'(out_valid_o), 32'd0);
        check("glitch_frames", 32'(n_acc - acc0), 32'd0);
        @(negedge clk_i);

        // Overrun: consumer stalled across two frames
        out_ready_i = 1'b0;
        ovr0 = n_ovr;
        send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        #1;
        check("overrun_pulses", 32'(n_ovr - ovr0), 32'd1);
        check("held_data", 32'(data_o), 32'h11);
        check("held_valid", 32'(out_valid_o), 32'd1);
        @(negedge clk_i);
        out_ready_i = 1'b1;
        drive(1'b1, 4);
        check("overrun_drained", 32'(exp_q.size()), 32'd0);

        // Consumer becomes ready before the second frame commits
        out_ready_i = 1'b0;
        ovr0 = n_ovr;
        send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        check("no_overrun", 32'(n_ovr - ovr0), 32'd0);

        // Reset during data bit 4, with a word already held
        out_ready_i = 1'b0;
        send_frame(8'h33, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        #1;
        check("pre_reset_valid", 32'(out_valid_o), 32'd1);
        @(negedge clk_i);
        d = 8'h5A;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(d[i], CPB);
        drive(d[4], CPB / 2);
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_values("midframe_reset");
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 2 * CPB);
        send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2);

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            send_frame(DB'($urandom), 2'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                       1'b1, 1'b0, $urandom_range(1, 3));
        end

        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk_i);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_overruns", 32'(n_ovr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
